// File: rtl/bcd_divider.sv
// bcd_divider: 4-digit packed-BCD dividend divided by a 1-digit BCD divisor using
// digit-serial long division by repeated subtraction, most significant digit first.
//
// state | meaning
// IDLE  | waiting for START; operands captured on acceptance
// LOAD  | partial = r*10 + digit[i], quotient digit cleared
// SUB   | subtract divisor while partial >= divisor, then store digit
// FIN   | results valid, one-cycle DONE pulse
module bcd_divider (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [15:0] DIVIDEND,
    input  logic [3:0]  DIVISOR,
    output logic [15:0] QUOTIENT,
    output logic [3:0]  REMAINDER,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SUB, S_FIN} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_dividend;
    logic [3:0]  r_divisor;
    logic [3:0]  r_rem;
    logic [1:0]  r_idx;
    logic [6:0]  r_partial;
    logic [3:0]  r_qd;
    logic [15:0] r_quot;
    logic [15:0] r_quotient_o;
    logic [3:0]  r_remainder_o;
    logic        r_err_o;

    logic        w_invalid;
    logic        w_sub_ge;
    logic [3:0]  w_digit;
    logic [6:0]  w_partial_ld;
    logic [15:0] w_quot_upd;
    logic        w_busy;
    logic        w_done;

    always_comb begin
        w_invalid = (DIVISOR == 4'd0) || (DIVISOR > 4'd9) ||
                    (DIVIDEND[15:12] > 4'd9) || (DIVIDEND[11:8] > 4'd9) ||
                    (DIVIDEND[7:4] > 4'd9)   || (DIVIDEND[3:0] > 4'd9);
    end

    always_comb begin
        w_digit = r_dividend[3:0];
        case (r_idx)
            2'd3:    w_digit = r_dividend[15:12];
            2'd2:    w_digit = r_dividend[11:8];
            2'd1:    w_digit = r_dividend[7:4];
            default: w_digit = r_dividend[3:0];
        endcase
    end

    // Quotient with the finished digit merged in, so the final digit can go
    // straight to the output register on the edge that enters FIN.
    always_comb begin
        w_quot_upd = r_quot;
        case (r_idx)
            2'd3:    w_quot_upd[15:12] = r_qd;
            2'd2:    w_quot_upd[11:8]  = r_qd;
            2'd1:    w_quot_upd[7:4]   = r_qd;
            default: w_quot_upd[3:0]   = r_qd;
        endcase
    end

    assign w_partial_ld = ({3'b000, r_rem} * 7'd10) + {3'b000, w_digit};
    assign w_sub_ge     = (r_partial >= {3'b000, r_divisor});

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (START) w_next = w_invalid ? S_FIN : S_LOAD;
            S_LOAD: w_next = S_SUB;
            S_SUB: begin
                if (!w_sub_ge) w_next = (r_idx == 2'd0) ? S_FIN : S_LOAD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
        w_done = (r_state == S_FIN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_dividend    <= '0;
            r_divisor     <= '0;
            r_rem         <= '0;
            r_idx         <= '0;
            r_partial     <= '0;
            r_qd          <= '0;
            r_quot        <= '0;
            r_quotient_o  <= '0;
            r_remainder_o <= '0;
            r_err_o       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_dividend <= DIVIDEND;
                        r_divisor  <= DIVISOR;
                        r_rem      <= '0;
                        r_idx      <= 2'd3;
                        r_partial  <= '0;
                        r_qd       <= '0;
                        r_quot     <= '0;
                        if (w_invalid) begin
                            r_quotient_o  <= '0;
                            r_remainder_o <= '0;
                            r_err_o       <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_partial <= w_partial_ld;
                    r_qd      <= '0;
                end
                S_SUB: begin
                    if (w_sub_ge) begin
                        r_partial <= r_partial - {3'b000, r_divisor};
                        r_qd      <= r_qd + 4'd1;
                    end else begin
                        r_quot <= w_quot_upd;
                        r_rem  <= r_partial[3:0];
                        if (r_idx == 2'd0) begin
                            r_quotient_o  <= w_quot_upd;
                            r_remainder_o <= r_partial[3:0];
                            r_err_o       <= 1'b0;
                        end else begin
                            r_idx <= r_idx - 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign QUOTIENT  = r_quotient_o;
    assign REMAINDER = r_remainder_o;
    assign ERR       = r_err_o;
    assign BUSY      = w_busy;
    assign DONE      = w_done;
endmodule

// File: tb/tb_bcd_divider.sv
// Bench for bcd_divider: directed cases plus randomized requests checked against
// an arithmetic reference (integer divide, decimal digit sum for latency).
module tb_bcd_divider;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [15:0] DIVIDEND = '0;
    logic [3:0]  DIVISOR = '0;
    logic [15:0] QUOTIENT;
    logic [3:0]  REMAINDER;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q = '0;
    logic [3:0]  exp_r = '0;
    logic        exp_e = 1'b0;

    bcd_divider dut (
        .CLK(CLK), .RST(RST), .START(START), .DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR),
        .QUOTIENT(QUOTIENT), .REMAINDER(REMAINDER), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model(input logic [15:0] dd, input logic [3:0] ds,
                         output logic [15:0] q, output logic [3:0] r,
                         output logic e, output int lat);
        int  v;
        int  qv;
        bit  bad;
        bad = (ds == 4'd0) || (ds > 4'd9);
        for (int d = 0; d < 4; d++) if (dd[d*4 +: 4] > 4'd9) bad = 1'b1;
        q = '0;
        if (bad) begin
            r = '0; e = 1'b1; lat = 0;
        end else begin
            v = int'(dd[15:12]) * 1000 + int'(dd[11:8]) * 100 + int'(dd[7:4]) * 10 + int'(dd[3:0]);
            qv = v / int'(ds);
            r = 4'(v % int'(ds));
            e = 1'b0;
            lat = 8;
            for (int d = 0; d < 4; d++) begin
                q[d*4 +: 4] = 4'(qv % 10);
                lat += qv % 10;
                qv = qv / 10;
            end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the
    // edge that leaves FIN. hold keeps START high; pulse fires START at edges 3 and 10.
    task automatic do_op(input logic [15:0] dd, input logic [3:0] ds, input bit hold, input bit pulse);
        logic [15:0] q;
        logic [3:0]  r;
        logic        e;
        int          lat;
        int          k;
        model(dd, ds, q, r, e, lat);
        START = 1'b1; DIVIDEND = dd; DIVISOR = ds;
        @(posedge CLK);
        @(negedge CLK);
        START = hold;
        DIVIDEND = 16'($urandom); DIVISOR = 4'($urandom);
        k = 0;
        while (!DONE && k < 100) begin
            check_val("busy", {31'd0, BUSY}, 32'd1);
            check_val("hold_q", {16'd0, QUOTIENT}, {16'd0, exp_q});
            START = hold || (pulse && (k == 2 || k == 9));
            DIVIDEND = 16'($urandom); DIVISOR = 4'($urandom);
            @(posedge CLK);
            @(negedge CLK);
            k++;
        end
        START = hold;
        check_val("latency", k, lat);
        check_val("quotient", {16'd0, QUOTIENT}, {16'd0, q});
        check_val("remainder", {28'd0, REMAINDER}, {28'd0, r});
        check_val("err", {31'd0, ERR}, {31'd0, e});
        check_val("busy_fin", {31'd0, BUSY}, 32'd1);
        exp_q = q; exp_r = r; exp_e = e;
        @(posedge CLK);
        @(negedge CLK);
        check_val("done_pulse", {31'd0, DONE}, 32'd0);
        check_val("busy_idle", {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        logic [15:0] dd;
        logic [3:0]  ds;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check_val("rst_q", {16'd0, QUOTIENT}, 32'd0);
        check_val("rst_flags", {28'd0, REMAINDER, BUSY, DONE, ERR}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);

        do_op(16'h1234, 4'd2, 1'b0, 1'b0);
        do_op(16'h9999, 4'd1, 1'b0, 1'b0);
        do_op(16'h0005, 4'd7, 1'b0, 1'b0);
        do_op(16'h1234, 4'd0, 1'b0, 1'b0);
        do_op(16'h12A4, 4'd3, 1'b0, 1'b0);
        do_op(16'h0042, 4'd6, 1'b0, 1'b0);
        do_op(16'h8000, 4'd9, 1'b0, 1'b1);

        // reset in the middle of a long request
        START = 1'b1; DIVIDEND = 16'h9999; DIVISOR = 4'd3;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (11) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check_val("midrst_q", {16'd0, QUOTIENT}, 32'd0);
        check_val("midrst_flags", {28'd0, REMAINDER, BUSY, DONE, ERR}, 32'd0);
        exp_q = '0; exp_r = '0; exp_e = 1'b0;
        do_op(16'h0100, 4'd4, 1'b0, 1'b0);

        // back-to-back with START held high
        do_op(16'h0777, 4'd7, 1'b1, 1'b0);
        do_op(16'h0000, 4'd5, 1'b1, 1'b0);
        do_op(16'h5F00, 4'd2, 1'b1, 1'b0);
        do_op(16'h0081, 4'd9, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            for (int d = 0; d < 4; d++) dd[d*4 +: 4] = 4'($urandom_range(0, 9));
            ds = 4'($urandom_range(1, 9));
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0) ds = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(10, 15));
                else dd[$urandom_range(0, 3)*4 +: 4] = 4'($urandom_range(10, 15));
            end
            do_op(dd, ds, ($urandom_range(0, 3) == 0), 1'b0);
        end
        START = 1'b0;
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
